// File: rtl/controller_pkg.sv
// Shared types for the controller memory blocks.
// Holds the block reader FSM state enum and the bus word stride.
package controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GAP,
    WAIT_SPACE,
    DRAIN
  } wbr_state_t;

  localparam int WORD_STRIDE = 4;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry valid/ready FIFO; push and pop in one cycle both apply.
// Ports: clk, rst, flush, s_data/s_valid in, m_data/m_valid/m_ready, count.
module stream_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  assign m_valid = (cnt != 2'd0);
  assign push    = s_valid && (cnt != 2'd2);
  assign pop     = m_valid && m_ready;
  assign m_data  = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/wb_block_reader.sv
// Wishbone-classic block reader: reads N words, streams them out.
// Ports: start/base/count cmd, busy/done/error status, wb master, stream.
// Optional WB_BLOCK_READER_TIMEOUT_EN: abort on missing ack.
import controller_pkg::*;

module wb_block_reader #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_BITS       = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_BITS-1:0]   word_count_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ack_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i
);

  wbr_state_t            state;
  wbr_state_t            state_n;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [LEN_BITS-1:0]   remaining;
  logic [LEN_BITS-1:0]   rem_n;
  logic                  busy_q;
  logic                  done_q;
  logic                  done_n;
  logic                  cyc_q;
  logic                  push;
  logic                  flush;
  logic                  pop;
  logic                  space_after;
  logic [1:0]            fifo_cnt;
  logic [DATA_WIDTH:0]   head;

`ifdef WB_BLOCK_READER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo;
  logic [TW-1:0] tmo_n;
  logic          err_q;
  logic          err_n;
`endif

  assign pop = m_valid_o && m_ready_i;

  // Room for another word once this cycle's push/pop settle.
  assign space_after = (fifo_cnt == 2'd0) ||
                       (fifo_cnt == 2'd1 && pop);

  always_comb begin
    state_n = state;
    addr_n  = cur_addr;
    rem_n   = remaining;
    push    = 1'b0;
    flush   = 1'b0;
    done_n  = 1'b0;
`ifdef WB_BLOCK_READER_TIMEOUT_EN
    tmo_n   = '0;
    err_n   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (start_i) begin
          addr_n = base_addr_i;
          rem_n  = word_count_i;
          if (word_count_i != '0) begin
            state_n = REQ;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      REQ: begin
        if (ack_i) begin
          push   = 1'b1;
          rem_n  = remaining - 1'b1;
          addr_n = cur_addr + ADDR_WIDTH'(WORD_STRIDE);
          if (remaining == LEN_BITS'(1)) begin
            state_n = DRAIN;
          end else if (space_after) begin
            state_n = GAP;
          end else begin
            state_n = WAIT_SPACE;
          end
        end
`ifdef WB_BLOCK_READER_TIMEOUT_EN
        else begin
          tmo_n = tmo + 1'b1;
          if (tmo_n == TW'(TIMEOUT_CYCLES - 1)) begin
            flush   = 1'b1;
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
`endif
      end
      GAP: begin
        state_n = REQ;
      end
      WAIT_SPACE: begin
        if (fifo_cnt != 2'd2) begin
          state_n = REQ;
        end
      end
      DRAIN: begin
        if (pop && m_last_o) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cyc_q     <= 1'b0;
    end else begin
      state     <= state_n;
      cur_addr  <= addr_n;
      remaining <= rem_n;
      busy_q    <= (state_n != IDLE);
      done_q    <= done_n;
      cyc_q     <= (state_n == REQ);
    end
  end

`ifdef WB_BLOCK_READER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo   <= '0;
      err_q <= 1'b0;
    end else begin
      tmo   <= tmo_n;
      err_q <= err_n;
    end
  end

  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

  stream_fifo2 #(
    .W (DATA_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .s_data  ({remaining == LEN_BITS'(1), data_i}),
    .s_valid (push),
    .m_data  (head),
    .m_valid (m_valid_o),
    .m_ready (m_ready_i),
    .count   (fifo_cnt)
  );

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign cyc_o    = cyc_q;
  assign stb_o    = cyc_q;
  assign we_o     = 1'b0;
  assign addr_o   = cur_addr;
  assign m_data_o = head[DATA_WIDTH-1:0];
  assign m_last_o = head[DATA_WIDTH] & m_valid_o;

endmodule

// File: doc/wb_block_reader.md
# wb_block_reader

Wishbone-classic bus initiator that reads a block of consecutive 32-bit words from a memory responder and streams them out over a valid/ready interface. It is the opposite end of the controller's memory responder ports: it drives `cyc/stb/we/addr` and consumes `ack/data`. It is used by the interpreter for memory dump commands, sitting between the command decoder and the UART TX path.

## Interface
- `ADDR_WIDTH`, 32: bus address width.
- `DATA_WIDTH`, 32: bus and stream data width.
- `LEN_BITS`, 16: width of the word-count field.
- `TIMEOUT_CYCLES`, 1024: maximum wait for `ack_i` per access; only used with timeout enabled.
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: reset. Synchronous, active-high.
- `start_i` input 1: one-cycle command pulse.
- `base_addr_i` input ADDR_WIDTH: byte address of the first word.
- `word_count_i` input LEN_BITS: number of words to read.
- `busy_o` output 1: a command is in progress.
- `done_o` output 1: one-cycle pulse when the command completes normally.
- `error_o` output 1: one-cycle pulse when the command aborts on timeout.
- `cyc_o`, `stb_o` output 1: Wishbone cycle and strobe.
- `we_o` output 1: tied to 0.
- `addr_o` output ADDR_WIDTH: bus address.
- `data_i` input DATA_WIDTH: read data.
- `ack_i` input 1: responder acknowledge.
- `m_data_o` output DATA_WIDTH: stream data.
- `m_valid_o` output 1: stream valid.
- `m_last_o` output 1: marks the final word of the block.
- `m_ready_i` input 1: stream ready.

## Operation
- FSM states: IDLE, REQ, GAP, WAIT_SPACE, DRAIN.
- **IDLE**
  - `start_i` latches `base_addr_i` into `cur_addr` and `word_count_i` into `remaining`.
  - If count ≠ 0, go to REQ and set `busy_o`.
  - If count = 0, pulse `done_o` on the next cycle, issue no bus cycle, and never assert `busy_o`.
- **REQ**
  - `cyc_o = stb_o = 1`, `addr_o = cur_addr`.
  - On `ack_i`:
    - push `data_i` into the output buffer, tagged last if `remaining == 1`;
    - decrement `remaining`; `cur_addr += 4`.
  - Then go to DRAIN if `remaining` is now 0. Otherwise go to GAP if the buffer has space after this push, else WAIT_SPACE.
- **GAP**
  - `cyc_o`/`stb_o` low for exactly one cycle, then REQ. Every word is a separate classic cycle.
- **WAIT_SPACE**
  - Bus idle until the buffer has a free entry, then REQ.
- **DRAIN**
  - Bus idle until the last-tagged word is accepted (`m_valid_o && m_ready_i`).
  - Then pulse `done_o`, clear `busy_o`, return to IDLE.
- Output buffer: 2-entry FIFO.
  - `m_valid_o` high while it is non-empty; head drives `m_data_o`/`m_last_o`.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
- `start_i` while `busy_o` is ignored.
- Address arithmetic is modulo 2^ADDR_WIDTH: 0xFFFFFFFC + 4 wraps to 0x00000000. The two low address bits are passed through from `base_addr_i` unchanged.
- `ack_i` outside REQ is ignored.

## Timing
- Reset values: `cyc_o`, `stb_o`, `we_o`, `busy_o`, `done_o`, `error_o`, `m_valid_o`, `m_last_o` are all 0; `addr_o` and `m_data_o` are 0; buffer empty; state IDLE.
- Reset mid-operation:
  - outputs take their reset values on the edge after `rst` is sampled high;
  - buffered data is discarded;
  - no `done_o`/`error_o` pulse.
- All outputs are registered.
- `start_i` sampled at edge t → `stb_o` high from t+1.
- `ack_i` sampled at edge t → word visible on `m_valid_o` from t+1.
- With a 1-cycle-ack responder and `m_ready_i = 1`, peak throughput is 1 word per 3 cycles.
- `done_o` is asserted on the cycle after the last word's stream handshake.
- `busy_o` falls together with the `done_o` or `error_o` pulse.

## Configuration
- Macro `WB_BLOCK_READER_TIMEOUT_EN`.
- **Defined:**
  - a counter starts at 0 on entry to REQ and increments each REQ cycle without `ack_i`;
  - reaching `TIMEOUT_CYCLES - 1` → drop `cyc_o`/`stb_o`, flush the buffer, pulse `error_o`, clear `busy_o`, return to IDLE.
- **Undefined:**
  - no counter is present; REQ waits indefinitely;
  - `error_o` is tied to 0.

## Structure
- Shared package `controller_pkg`: FSM state enum `wbr_state_t` and the constant `WORD_STRIDE = 4`.
- One sub-module: `stream_fifo2`, the 2-entry valid/ready FIFO carrying `{last, data}`.
- FSM, address/count registers and timeout counter live in the top module.

## Test plan
- **Basic read:** memory[0x100..0x10C] = 0xA0..0xA3; start base 0x100, count 4, ready=1 → stream A0,A1,A2,A3 with `m_last_o` only on A3; `addr_o` sequence 0x100/104/108/10C; one `done_o` pulse.
- **Backpressure:** count 5, `m_ready_i` = 0 for 20 cycles → bus stalls after 2 acks in WAIT_SPACE with `cyc_o` = 0; after release all 5 words arrive in order, none lost or duplicated.
- **Zero count and wrap:**
  - count 0 → `done_o` one cycle later, `cyc_o` never high;
  - base 0xFFFFFFFC, count 2 → addresses 0xFFFFFFFC then 0x00000000.
- **Timeout (macro defined):**
  - `TIMEOUT_CYCLES` 8, responder never acks → `error_o` pulses on the 8th REQ cycle, `cyc_o` low, `m_valid_o` 0, `busy_o` 0;
  - with the macro undefined the same stimulus keeps `stb_o` high.
- **Reset and ignored start:**
  - `rst` asserted mid-block after 2 words → all outputs at reset values on the next cycle;
  - `start_i` pulsed while busy → no change to `addr_o` sequence or count.
